// File: rtl/uart_cmd_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// uart_cmd_decoder : byte FIFO + FSM turning UART command bytes into pulses
// Revision: 1.0
// ============================================================================
module uart_cmd_decoder #(
  parameter int DEPTH = 8,
  parameter int ECHO  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               rx_data,
  input  logic                     rx_done,
  input  logic                     tx_busy,
  input  logic                     tx_done,
  output logic                     run_stop,
  output logic                     clear,
  output logic                     mode,
  output logic [7:0]               tx_data,
  output logic                     start_trigger,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    SEND   = 2'd2,
    WAIT   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [7:0]       mem_q [DEPTH];
  logic [7:0]       mem_d [DEPTH];
  logic [7:0]       cmd_q, cmd_d;
  logic             overflow_q, overflow_d;
  logic             run_stop_q, run_stop_d;
  logic             clear_q, clear_d;
  logic             mode_q, mode_d;
  logic             start_q, start_d;
  logic             push, pop;
  logic [7:0]       head;

  // Fullness is judged on the registered count, so a same-cycle pop never frees a slot.
  assign push = rx_done && (count_q != FULL_CNT);
  assign head = mem_q[rd_ptr_q];

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    run_stop_d = 1'b0;
    clear_d    = 1'b0;
    mode_d     = 1'b0;
    start_d    = 1'b0;
    pop        = 1'b0;

    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          cmd_d   = head;
          state_d = DECODE;
          // Pulses are registered on the IDLE->DECODE edge so they sit in DECODE.
          case (head)
            8'h52, 8'h72: run_stop_d = 1'b1;
            8'h43, 8'h63: clear_d    = 1'b1;
            8'h4D, 8'h6D: mode_d     = 1'b1;
            default: ;
          endcase
        end
      end
      DECODE: state_d = (ECHO != 0) ? SEND : IDLE;
      SEND: begin
        if (!tx_busy) begin
          start_d = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (tx_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (rx_done & ~push);
    if (push) begin
      mem_d[wr_ptr_q] = rx_data;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      cmd_q      <= 8'h00;
      overflow_q <= 1'b0;
      run_stop_q <= 1'b0;
      clear_q    <= 1'b0;
      mode_q     <= 1'b0;
      start_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      cmd_q      <= cmd_d;
      overflow_q <= overflow_d;
      run_stop_q <= run_stop_d;
      clear_q    <= clear_d;
      mode_q     <= mode_d;
      start_q    <= start_d;
    end
  end

  // Storage needs no reset: the pointers and count decide what is valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
  end

  assign run_stop      = run_stop_q;
  assign clear         = clear_q;
  assign mode          = mode_q;
  assign start_trigger = start_q;
  assign tx_data       = cmd_q;
  assign fifo_count    = count_q;
  assign overflow      = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_uart_cmd_decoder : directed self-checking bench (ECHO=1 and ECHO=0 DUTs)
// Revision: 1.0
// ============================================================================
module tb_uart_cmd_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_done, tx_busy, tx_done;
  logic       run_stop, clear, mode, start_trigger, overflow;
  logic [7:0] tx_data;
  logic [3:0] fifo_count;

  logic [7:0] rx_data0;
  logic       rx_done0, tx_busy0, tx_done0;
  logic       run_stop0, clear0, mode0, start_trigger0, overflow0;
  logic [7:0] tx_data0;
  logic [3:0] fifo_count0;

  int         n_checks = 0;
  int         n_errors = 0;
  int         multi_hot = 0;
  int         start0_seen = 0;
  int         rsp_cnt = 0;
  logic       tx_auto = 1'b0;
  logic [7:0] pulse_log[$];
  logic [7:0] echo_log[$];
  int         bp, be;

  always #5 clk = ~clk;

  uart_cmd_decoder #(.DEPTH(8), .ECHO(1)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done),
    .tx_busy(tx_busy), .tx_done(tx_done), .run_stop(run_stop),
    .clear(clear), .mode(mode), .tx_data(tx_data),
    .start_trigger(start_trigger), .fifo_count(fifo_count),
    .overflow(overflow)
  );

  uart_cmd_decoder #(.DEPTH(8), .ECHO(0)) dut0 (
    .clk(clk), .rst(rst), .rx_data(rx_data0), .rx_done(rx_done0),
    .tx_busy(tx_busy0), .tx_done(tx_done0), .run_stop(run_stop0),
    .clear(clear0), .mode(mode0), .tx_data(tx_data0),
    .start_trigger(start_trigger0), .fifo_count(fifo_count0),
    .overflow(overflow0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Log decoded pulses and echoes; emulate a transmitter that finishes 2 cycles after a start.
  always @(negedge clk) begin
    tx_done = 1'b0;
    if (!tx_auto) rsp_cnt = 0;
    else begin
      if (rsp_cnt > 0) begin
        rsp_cnt--;
        if (rsp_cnt == 0) tx_done = 1'b1;
      end
      if (start_trigger) rsp_cnt = 2;
    end
    if (rst) begin
      if (run_stop) pulse_log.push_back(8'h52);
      if (clear)    pulse_log.push_back(8'h43);
      if (mode)     pulse_log.push_back(8'h4D);
      if (int'(run_stop) + int'(clear) + int'(mode) > 1) multi_hot++;
      if (start_trigger) echo_log.push_back(tx_data);
      if (start_trigger0) start0_seen++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    step(1);
    rx_done = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step(2);
    rst = 1'b1;
    step(1);
  endtask

  task automatic wait_drained(input int max_cyc, input string tag);
    int k;
    k = 0;
    while (!(int'(dut.state_q) == 0 && fifo_count == 4'd0) && k < max_cyc) begin
      step(1);
      k++;
    end
    check(tag, 32'(k < max_cyc), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; rx_data = 8'h00; rx_done = 1'b0; tx_busy = 1'b0;
    rx_data0 = 8'h00; rx_done0 = 1'b0; tx_busy0 = 1'b0; tx_done0 = 1'b0;
    step(2);
    check("rst_count",    32'(fifo_count), 32'd0);
    check("rst_outs",     {27'd0, run_stop, clear, mode, start_trigger, overflow}, 32'd0);
    check("rst_txdata",   32'(tx_data), 32'h00);
    rst = 1'b1;
    step(1);

    // Single 'r' with exact latency
    tx_auto = 1'b1;
    push_byte(8'h72);
    check("r_count_n1",   32'(fifo_count), 32'd1);
    step(1);
    check("r_runstop_n2", {29'd0, run_stop, clear, mode}, 32'b100);
    step(1);
    check("r_pulse_gone", {30'd0, run_stop, start_trigger}, 32'd0);
    step(1);
    check("r_start",      32'(start_trigger), 32'd1);
    check("r_txdata",     32'(tx_data), 32'h72);
    step(1);
    check("r_start_once", 32'(start_trigger), 32'd0);
    check("r_in_wait",    32'(int'(dut.state_q)), 32'd3);
    step(2);
    check("r_idle",       32'(int'(dut.state_q)), 32'd0);

    // Burst 'C','m','x' with transmitter busy
    bp = pulse_log.size(); be = echo_log.size();
    tx_busy = 1'b1;
    push_byte(8'h43); push_byte(8'h6D); push_byte(8'h78);
    step(100);
    check("b_pulses_busy", 32'(pulse_log.size() - bp), 32'd1);
    check("b_first_clear", 32'(pulse_log[bp]), 32'h43);
    check("b_queued",      32'(fifo_count), 32'd2);
    check("b_no_echo_yet", 32'(echo_log.size() - be), 32'd0);
    tx_busy = 1'b0;
    wait_drained(200, "b_drain");
    step(2);
    check("b_pulses",  32'(pulse_log.size() - bp), 32'd2);
    check("b_mode",    32'(pulse_log[bp+1]), 32'h4D);
    check("b_echoes",  32'(echo_log.size() - be), 32'd3);
    check("b_echo0",   32'(echo_log[be]),   32'h43);
    check("b_echo1",   32'(echo_log[be+1]), 32'h6D);
    check("b_echo2",   32'(echo_log[be+2]), 32'h78);

    // Overflow: 10 bytes into 8 slots, then a push coinciding with a pop
    do_reset();
    check("o_ovf_clear", 32'(overflow), 32'd0);
    bp = pulse_log.size(); be = echo_log.size();
    tx_busy = 1'b1;
    push_byte(8'h21);
    step(2);
    for (int i = 0; i < 8; i++) push_byte(8'h30 + 8'(i));
    check("o_full",     32'(fifo_count), 32'd8);
    check("o_no_ovf",   32'(overflow), 32'd0);
    push_byte(8'h38);
    check("o_ovf_set",  32'(overflow), 32'd1);
    push_byte(8'h39);
    check("o_sat",      32'(fifo_count), 32'd8);
    tx_busy = 1'b0;
    begin
      int k;
      k = 0;
      while (int'(dut.state_q) != 0 && k < 50) begin step(1); k++; end
      check("o_reach_idle", 32'(k < 50), 32'd1);
    end
    push_byte(8'h41);
    check("o_pushpop_cnt", 32'(fifo_count), 32'd7);
    check("o_pushpop_ovf", 32'(overflow), 32'd1);
    wait_drained(300, "o_drain");
    step(4);
    check("o_echo_cnt", 32'(echo_log.size() - be), 32'd9);
    check("o_echo_first", 32'(echo_log[be]), 32'h21);
    for (int i = 0; i < 8; i++)
      check($sformatf("o_echo%0d", i + 1), 32'(echo_log[be+1+i]), 32'h30 + 32'(i));
    check("o_no_pulses", 32'(pulse_log.size() - bp), 32'd0);
    check("o_ovf_sticky", 32'(overflow), 32'd1);

    // Reset while waiting on the transmitter with 3 bytes queued
    do_reset();
    tx_auto = 1'b0; tx_busy = 1'b0;
    push_byte(8'h52); push_byte(8'h43); push_byte(8'h4D); push_byte(8'h72);
    step(3);
    check("w_queued",  32'(fifo_count), 32'd3);
    check("w_in_wait", 32'(int'(dut.state_q)), 32'd3);
    check("w_txdata",  32'(tx_data), 32'h52);
    bp = pulse_log.size(); be = echo_log.size();
    #2 rst = 1'b0;
    #1;
    check("w_rst_count",  32'(fifo_count), 32'd0);
    check("w_rst_txdata", 32'(tx_data), 32'h00);
    check("w_rst_outs",   {27'd0, run_stop, clear, mode, start_trigger, overflow}, 32'd0);
    step(1);
    rst = 1'b1;
    step(10);
    check("w_no_pulses", 32'(pulse_log.size() - bp), 32'd0);
    check("w_no_echo",   32'(echo_log.size() - be), 32'd0);
    check("w_empty",     32'(fifo_count), 32'd0);

    // ECHO=0: 'M' pulses mode, never starts a transmit
    rx_data0 = 8'h4D; rx_done0 = 1'b1;
    step(1);
    rx_done0 = 1'b0;
    check("e0_count",  32'(fifo_count0), 32'd1);
    step(1);
    check("e0_mode",   {29'd0, run_stop0, clear0, mode0}, 32'b001);
    step(1);
    check("e0_idle",   32'(int'(dut0.state_q)), 32'd0);
    check("e0_mode_off", 32'(mode0), 32'd0);
    step(5);
    check("e0_no_start", 32'(start0_seen), 32'd0);

    check("one_hot_pulses", 32'(multi_hot), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
